// File: rtl/audio_env_pwm.sv
// audio_env_pwm: ADSR envelope applied to a 1-bit square wave by PWM chopping
//   clk, rst_n (async active-low) | audio_in: synth square wave | gate: note held
//   silence: mute, clears envelope | audio_out: enveloped PWM audio (registered)
//   env_level: current envelope level | env_busy: envelope FSM not idle
module audio_env_pwm #(
  parameter int PWM_W       = 6,
  parameter int ATTACK_DIV  = 256,
  parameter int ATTACK_STEP = 8,
  parameter int DECAY_DIV   = 4096,
  parameter int SUSTAIN     = 24,
  parameter int RELEASE_DIV = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             audio_in,
  input  logic             gate,
  input  logic             silence,
  output logic             audio_out,
  output logic [PWM_W-1:0] env_level,
  output logic             env_busy
);
  localparam int MAXDIV = ATTACK_DIV > DECAY_DIV ?
                          (ATTACK_DIV > RELEASE_DIV ? ATTACK_DIV : RELEASE_DIV) :
                          (DECAY_DIV > RELEASE_DIV ? DECAY_DIV : RELEASE_DIV);
  localparam int TW = $clog2(MAXDIV + 1);
  localparam logic [PWM_W-1:0] MAX = '1;
  typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_DECAY, S_SUST, S_RELEASE} state_t;
  state_t           state;
  logic [TW-1:0]    tcnt, div;
  logic [PWM_W-1:0] pwm_ctr, level_lat;
  logic [PWM_W:0]   sum;
  logic             gate_q, rise, fall, tick, active;
  always_comb begin
    rise   = gate & ~gate_q;
    fall   = ~gate & gate_q;
    div    = state == S_ATTACK ? TW'(ATTACK_DIV - 1) :
             state == S_DECAY  ? TW'(DECAY_DIV - 1)  : TW'(RELEASE_DIV - 1);
    tick   = tcnt == div;
    sum    = {1'b0, env_level} + (PWM_W + 1)'(ATTACK_STEP);
    active = state == S_ATTACK || state == S_DECAY || state == S_SUST;
    env_busy = state != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      pwm_ctr   <= '0;
      level_lat <= '0;
      gate_q    <= 1'b0;
      env_level <= '0;
      audio_out <= 1'b0;
    end else begin
      gate_q    <= gate;
      pwm_ctr   <= pwm_ctr + 1'b1;
      // latch only at period end so a level change never cuts a pulse short
      if (pwm_ctr == MAX) level_lat <= env_level;
      audio_out <= audio_in & ~silence & (pwm_ctr < level_lat);
      tcnt      <= tick ? '0 : tcnt + 1'b1;
      if (silence) begin
        state     <= S_IDLE;
        env_level <= '0;
        tcnt      <= '0;
      end else if (rise) begin
        state <= S_ATTACK;
        tcnt  <= '0;
      end else if (fall) begin
        tcnt <= '0;
        if (active) state <= S_RELEASE;
      end else begin
        case (state)
          S_ATTACK: if (tick) begin
            if (sum >= {1'b0, MAX}) begin
              env_level <= MAX;
              state     <= S_DECAY;
              tcnt      <= '0;
            end else env_level <= sum[PWM_W-1:0];
          end
          S_DECAY: if (env_level <= PWM_W'(SUSTAIN)) begin
            state <= S_SUST;
            tcnt  <= '0;
          end else if (tick) begin
            env_level <= env_level - 1'b1;
            if (env_level == PWM_W'(SUSTAIN + 1)) begin
              state <= S_SUST;
              tcnt  <= '0;
            end
          end
          S_RELEASE: if (env_level == '0) begin
            state <= S_IDLE;
            tcnt  <= '0;
          end else if (tick) begin
            env_level <= env_level - 1'b1;
            if (env_level == PWM_W'(1)) begin
              state <= S_IDLE;
              tcnt  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
